fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Owns the program counter and drives the instruction ROM address.
- Registers the fetched 9-bit machine word into an instruction register (IR). The IR feeds the decoder's instAddress input.
- Consumes the decoder's jump_en/branch_en redirect requests. Targets come from an internal loadable lookup table (LUT).
- Sequences the program through start, run and halt, and provides a run-cycle counter.

Parameters:
- PC_W, 10: program counter and ROM address width.
- INST_W, 9: instruction width.
- START_ADDR, 0: PC value loaded on reset and on Start.
- LUT_DEPTH, 32: number of jump-target entries; index width is log2(LUT_DEPTH).
- HALT_OP, 9'h1FF: instruction encoding that ends the program.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  begin or restart program execution.
- Stall  in  1  freeze the fetch stage this cycle.
- jump_en  in  1  unconditional redirect request from the decoder.
- branch_en  in  1  taken-branch redirect request from the decoder (ZERO already applied).
- target_idx  in  5  LUT index for the redirect target.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  5  LUT write index.
- lut_wdata  in  PC_W  LUT write data.
- rom_data  in  INST_W  combinational instruction ROM read data for rom_addr.
- rom_addr  out  PC_W  current PC, driven to the ROM.
- instAddress  out  INST_W  IR contents (machine code) to the decoder.
- inst_valid  out  1  IR holds a live instruction.
- ProgCtr  out  PC_W  address of the instruction currently in the IR.
- Done  out  1  program halted.
- cycle_count  out  16  cycles spent in RUN.

Behaviour:
- Reset (Reset==0 at a clock edge, in any state, including mid-run):
  - State goes to IDLE.
  - PC=START_ADDR, IR=0, ProgCtr=0, inst_valid=0, Done=0, cycle_count=0.
  - LUT contents are retained.
- States: IDLE, RUN, HALT. rom_addr always equals PC.
- IDLE:
  - PC is held at START_ADDR.
  - Start=1 moves the state to RUN on the next edge.
- RUN, with Stall=0 and no redirect:
  - IR<=rom_data, ProgCtr<=PC, inst_valid<=1.
  - PC<=PC+1, wrapping modulo 2^PC_W (max address goes to 0).
- Redirect condition: inst_valid && (jump_en || branch_en) && Stall==0.
  - PC<=LUT[target_idx].
  - inst_valid<=0: the word fetched behind the redirecting instruction is squashed. This is exactly one bubble.
  - A target_idx >= LUT_DEPTH reads entry 0.
- Stall=1 in RUN:
  - PC, IR, ProgCtr and inst_valid all hold.
  - Any redirect request is ignored that cycle. The decoder re-presents it because the IR is held.
  - cycle_count still increments.
- Halt condition: inst_valid && IR==HALT_OP && Stall==0.
  - Takes priority over a redirect.
  - Next state is HALT: Done<=1, inst_valid<=0, PC frozen.
  - ProgCtr keeps the halt instruction's address.
- HALT:
  - Outputs are held and Done stays 1.
  - Start=1 performs a restart: PC<=START_ADDR, cycle_count<=0, Done<=0, state goes to RUN.
- Start while in RUN is ignored.
- cycle_count increments once per cycle while in RUN and saturates at 16'hFFFF.
- LUT:
  - Synchronous write, accepted only when lut_we=1 in IDLE or HALT; ignored in RUN.
  - Read is combinational.
  - Write and redirect read of the same entry cannot coincide, because writes are blocked in RUN.
- Latency from Start:
  - Start sampled high at edge 0.
  - RUN from edge 1 with rom_addr=START_ADDR.
  - First inst_valid=1 after edge 2.
  - Steady state: one instruction per cycle.

Test Plan:
- Reset and start: drive Reset low for 2 cycles, then Start=1 for 1 cycle. Required: all outputs zero after reset; rom_addr=0 at edge 1; ProgCtr=0 with inst_valid=1 after edge 2; rom_addr=1, 2, 3 on successive cycles.
- Jump with bubble: LUT[3]=10'h040 written in IDLE; ROM[2] decodes with jump_en=1 and target_idx=3. Required: inst_valid=0 on the following cycle; next valid instruction has ProgCtr=10'h040.
- Stall during redirect: Stall=1 for 2 cycles while branch_en=1. Required: PC, IR and ProgCtr unchanged and cycle_count +2; after Stall drops, redirect is taken once.
- Halt: ROM[5]=9'h1FF. Required: Done=1 one cycle after IR=9'h1FF; inst_valid=0; PC frozen at 6; cycle_count stops. Then Start=1 gives Done=0, rom_addr=0, cycle_count=0.
- Wrap and saturation: PC=10'h3FF with sequential fetch gives next rom_addr=0. A long run reaches cycle_count=16'hFFFF and holds there.
- Reset mid-run and LUT protection: lut_we=1 during RUN leaves the LUT entry unchanged. Reset asserted mid-run returns to IDLE with PC=0 on the next edge while LUT contents persist.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: the instruction ROM port plus the decoder-facing IR and
// redirect request signals. The fetch unit is the master side.
interface fetch_unit_if #(
    parameter int PC_W   = 10,
    parameter int INST_W = 9,
    parameter int IDX_W  = 5
);
    logic [PC_W-1:0]   rom_addr;
    logic [INST_W-1:0] rom_data;
    logic [INST_W-1:0] instAddress;
    logic              inst_valid;
    logic [PC_W-1:0]   ProgCtr;
    logic              jump_en;
    logic              branch_en;
    logic [IDX_W-1:0]  target_idx;

    modport master (
        output rom_addr,
        output instAddress,
        output inst_valid,
        output ProgCtr,
        input  rom_data,
        input  jump_en,
        input  branch_en,
        input  target_idx
    );

    modport slave (
        input  rom_addr,
        input  instAddress,
        input  inst_valid,
        input  ProgCtr,
        output rom_data,
        output jump_en,
        output branch_en,
        output target_idx
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers ROM words into the IR, takes
// LUT-targeted redirects from the decoder and sequences IDLE/RUN/HALT.
module fetch_unit #(
    parameter int                PC_W       = 10,
    parameter int                INST_W     = 9,
    parameter logic [PC_W-1:0]   START_ADDR = {PC_W{1'b0}},
    parameter int                LUT_DEPTH  = 32,
    parameter logic [INST_W-1:0] HALT_OP    = 9'h1FF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            lut_we,
    input  logic [4:0]      lut_waddr,
    input  logic [PC_W-1:0] lut_wdata,
    fetch_unit_if.master    fu,
    output logic            Done,
    output logic [15:0]     cycle_count
);

    localparam int          IDX_W   = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t            state_r;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   prog_ctr_r;
    logic [INST_W-1:0] ir_r;
    logic              valid_r;
    logic              done_r;
    logic [15:0]       count_r;
    logic [PC_W-1:0]   lut_r [LUT_DEPTH];

    logic [PC_W-1:0]   lut_rd_s;
    logic              in_run_s;
    logic              halt_s;
    logic              redirect_s;
    logic              lut_wr_s;
    logic [15:0]       count_inc_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    function automatic logic idx_in_range(input logic [4:0] idx);
        return (32'(idx) < LUT_DEPTH);
    endfunction

    // Redirect target lookup; indices beyond the table fall back to entry 0.
    always_comb begin
        lut_rd_s = lut_r[0];
        if (idx_in_range(fu.target_idx)) begin
            lut_rd_s = lut_r[fu.target_idx[IDX_W-1:0]];
        end else begin
            lut_rd_s = lut_r[0];
        end
    end

    // Per-cycle control decisions; halt outranks a redirect on the same cycle.
    always_comb begin
        in_run_s    = (state_r == ST_RUN);
        halt_s      = in_run_s && valid_r && !Stall && (ir_r == HALT_OP);
        redirect_s  = in_run_s && valid_r && !Stall && (fu.jump_en || fu.branch_en) && !halt_s;
        lut_wr_s    = Reset && lut_we && !in_run_s && idx_in_range(lut_waddr);
        count_inc_s = sat_inc(count_r);
    end

    // Sequencer FSM together with PC, IR, valid, Done and run-cycle counter.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= START_ADDR;
            ir_r       <= {INST_W{1'b0}};
            prog_ctr_r <= {PC_W{1'b0}};
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pc_r <= START_ADDR;
                    if (Start) begin
                        state_r <= ST_RUN;
                        count_r <= 16'd0;
                    end
                end
                ST_RUN: begin
                    count_r <= count_inc_s;
                    if (halt_s) begin
                        state_r <= ST_HALT;
                        done_r  <= 1'b1;
                        valid_r <= 1'b0;
                    end else if (redirect_s) begin
                        // The word fetched behind the redirecting instruction is dropped.
                        pc_r    <= lut_rd_s;
                        valid_r <= 1'b0;
                    end else if (!Stall) begin
                        ir_r       <= fu.rom_data;
                        prog_ctr_r <= pc_r;
                        valid_r    <= 1'b1;
                        pc_r       <= pc_r + PC_W'(1'b1);
                    end
                end
                ST_HALT: begin
                    if (Start) begin
                        state_r <= ST_RUN;
                        pc_r    <= START_ADDR;
                        count_r <= 16'd0;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    pc_r    <= START_ADDR;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    count_r <= 16'd0;
                end
            endcase
        end
    end

    // Jump-target table: not reset, writable only while the program is not running.
    always_ff @(posedge Clk) begin
        if (lut_wr_s) begin
            lut_r[lut_waddr[IDX_W-1:0]] <= lut_wdata;
        end
    end

    assign fu.rom_addr    = pc_r;
    assign fu.instAddress = ir_r;
    assign fu.inst_valid  = valid_r;
    assign fu.ProgCtr     = prog_ctr_r;
    assign Done           = done_r;
    assign cycle_count    = count_r;

endmodule
